coin_vend_ctrl: RTL
===================

# coin_vend_ctrl

Clocked, parametrised coin-acceptor and vending controller; successor to the combinational coin machine. Accepts nickel/dime/quarter strobes and accumulates credit up to a programmable price. Dispenses once the price is reached, then pays change back one coin per cycle using a greedy quarter/dime/nickel sequence. A cancel request refunds the full credit. Sits between the coin-slot sensors and the dispense/coin-return actuators.

## Interface
- PRICE, 35: item price in cents; multiple of 5, ≥ 5.
- MAX_CREDIT, 100: credit ceiling in cents; multiple of 5, ≥ PRICE, < 2**WIDTH.
- WIDTH, 8: credit counter width in bits.
- clk  in  1  system clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- nickel  in  1  coin level, synchronous to clk; each rising edge is one 5c coin.
- dime  in  1  each rising edge is one 10c coin.
- quarter  in  1  each rising edge is one 25c coin.
- cancel  in  1  level; refund request.
- count  out  WIDTH  current credit in cents.
- dispenseNoBalance  out  1  one-cycle pulse: item dispensed, exact credit.
- dispenseBalance  out  1  one-cycle pulse: item dispensed, change follows.
- returnQuarter / returnDime / returnNickel  out  1 each  one-cycle coin-return pulses.
- coinReject  out  1  one-cycle pulse: the detected coin was not credited.
- busy  out  1  high in DISPENSE and CHANGE.

## Operation
- Edge detection: a previous-level register per coin input. edge = level & ~prev. During reset, prev loads the current level, so a coin held through reset is never credited.
- State machine: IDLE (count = 0), ACCUM (0 < count < PRICE), DISPENSE, CHANGE.
- IDLE/ACCUM, exactly one coin edge:
  - If count + value > MAX_CREDIT: coinReject; count unchanged.
  - Otherwise count += value.
  - If the new count ≥ PRICE, next state is DISPENSE; else ACCUM.
- Two or more coin edges in the same cycle: coinReject; nothing credited.
- Coin edges in DISPENSE or CHANGE: coinReject; nothing credited.
- DISPENSE lasts one cycle:
  - count == PRICE: pulse dispenseNoBalance, count ← 0, go to IDLE.
  - Otherwise: pulse dispenseBalance, count ← count − PRICE, go to CHANGE.
- CHANGE, one coin per cycle, then count ← count − coin:
  - count ≥ 25: returnQuarter.
  - Else count ≥ 10: returnDime.
  - Else: returnNickel.
  - Go to IDLE in the cycle count reaches 0.
- cancel:
  - In ACCUM, with no coin edge that cycle: go to CHANGE and refund the full credit; no dispense pulse.
  - A coin edge in the same cycle takes priority; cancel is evaluated again next cycle.
  - Ignored in IDLE, DISPENSE and CHANGE.
- Arithmetic is unsigned WIDTH-bit. The MAX_CREDIT check prevents any overflow or underflow.

## Timing
- All outputs are registered.
- Reset values: count = 0, every pulse output = 0, busy = 0, state = IDLE. Reset overrides everything, including mid-DISPENSE or mid-CHANGE: outputs clear at the first edge with reset high, and the pending credit is discarded.
- Coin edge sampled at edge N: count updated after edge N; coinReject, if any, is high for the cycle after edge N.
- Credit reaches PRICE at edge N: busy rises after edge N; the dispense pulse and the count reduction occur after edge N+1.
- Change coin k (k = 1, 2, …) is pulsed after edge N+1+k; each return pulse lasts exactly one cycle.
- busy falls in the cycle count reaches 0.
- At most one return pulse and at most one dispense pulse per cycle; never both in the same cycle.

## Test plan
- nickel, dime, quarter edges, 5 cycles apart, PRICE = 35 → count 5, 15, 40 → dispenseBalance once, count 5 → returnNickel once → count 0, IDLE, busy low.
- dime then quarter → count 35 → dispenseNoBalance one cycle later; no return pulses; count 0.
- quarter held high for 10 cycles → exactly one credit of 25; no coinReject.
- nickel and dime rising in the same cycle → coinReject one cycle; count unchanged at 0. Quarter edge during CHANGE → coinReject; change sequence unaffected.
- quarter, dime, then cancel (count 35 not yet ≥ PRICE only if PRICE = 40; run with PRICE = 40) → returnQuarter, then returnDime; no dispense pulse; count 0.
- Reset asserted during CHANGE with 30c pending → next cycle count 0, all pulses 0, IDLE. quarter held high through reset release → no credit.

Source files
------------

// File: rtl/coin_vend_ctrl.sv
// Coin acceptor / vending controller: credits single coin edges, dispenses at PRICE, pays change greedily.
// All outputs registered: coin credit visible one cycle after its edge; dispense one cycle after busy rises.
module coin_vend_ctrl #(
  parameter int unsigned PRICE      = 35,
  parameter int unsigned MAX_CREDIT = 100,
  parameter int unsigned WIDTH      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             nickel,
  input  logic             dime,
  input  logic             quarter,
  input  logic             cancel,
  output logic [WIDTH-1:0] count,
  output logic             dispenseNoBalance,
  output logic             dispenseBalance,
  output logic             returnQuarter,
  output logic             returnDime,
  output logic             returnNickel,
  output logic             coinReject,
  output logic             busy
);
  localparam int unsigned     W1      = WIDTH + 1;
  localparam logic [W1-1:0]   PRICE_X = W1'(PRICE);
  localparam logic [W1-1:0]   MAX_X   = W1'(MAX_CREDIT);
  localparam logic [WIDTH-1:0] PRICE_C = WIDTH'(PRICE);
  localparam logic [WIDTH-1:0] C25     = WIDTH'(25);
  localparam logic [WIDTH-1:0] C10     = WIDTH'(10);
  localparam logic [WIDTH-1:0] C5      = WIDTH'(5);

  typedef enum logic [1:0] {IDLE, ACCUM, DISPENSE, CHANGE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       prev_q, prev_d;
  logic [2:0]       coin_lvl, coin_edge;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] change_coin;
  logic [W1-1:0]    coin_val, sum;
  logic             dnb_q, dnb_d, db_q, db_d;
  logic             rq_q, rq_d, rd_q, rd_d, rn_q, rn_d;
  logic             rej_q, rej_d, busy_q, busy_d;

  assign coin_lvl  = {quarter, dime, nickel};
  assign coin_edge = coin_lvl & ~prev_q;

  always_comb begin
    state_d     = state_q;
    prev_d      = coin_lvl;
    count_d     = count_q;
    dnb_d       = 1'b0;
    db_d        = 1'b0;
    rq_d        = 1'b0;
    rd_d        = 1'b0;
    rn_d        = 1'b0;
    rej_d       = 1'b0;
    change_coin = '0;
    coin_val    = '0;
    case (coin_edge)
      3'b001:  coin_val = W1'(5);
      3'b010:  coin_val = W1'(10);
      3'b100:  coin_val = W1'(25);
      default: coin_val = '0;
    endcase
    // Widened by one bit so the ceiling check cannot wrap.
    sum = {1'b0, count_q} + coin_val;

    case (state_q)
      IDLE, ACCUM: begin
        if (coin_edge != 3'b000) begin
          if ($countones(coin_edge) != 1 || sum > MAX_X) begin
            rej_d = 1'b1;
          end else begin
            count_d = sum[WIDTH-1:0];
            state_d = (sum >= PRICE_X) ? DISPENSE : ACCUM;
          end
        end else if (cancel && state_q == ACCUM) begin
          state_d = CHANGE;
        end
      end
      DISPENSE: begin
        rej_d = |coin_edge;
        if (count_q == PRICE_C) begin
          dnb_d   = 1'b1;
          count_d = '0;
          state_d = IDLE;
        end else begin
          db_d    = 1'b1;
          count_d = count_q - PRICE_C;
          state_d = CHANGE;
        end
      end
      CHANGE: begin
        rej_d = |coin_edge;
        if (count_q >= C25) begin
          rq_d        = 1'b1;
          change_coin = C25;
        end else if (count_q >= C10) begin
          rd_d        = 1'b1;
          change_coin = C10;
        end else begin
          rn_d        = 1'b1;
          change_coin = C5;
        end
        count_d = count_q - change_coin;
        if (count_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == DISPENSE) || (state_d == CHANGE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      prev_q  <= coin_lvl;
      count_q <= '0;
      dnb_q   <= 1'b0;
      db_q    <= 1'b0;
      rq_q    <= 1'b0;
      rd_q    <= 1'b0;
      rn_q    <= 1'b0;
      rej_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      count_q <= count_d;
      dnb_q   <= dnb_d;
      db_q    <= db_d;
      rq_q    <= rq_d;
      rd_q    <= rd_d;
      rn_q    <= rn_d;
      rej_q   <= rej_d;
      busy_q  <= busy_d;
    end
  end

  assign count             = count_q;
  assign dispenseNoBalance = dnb_q;
  assign dispenseBalance   = db_q;
  assign returnQuarter     = rq_q;
  assign returnDime        = rd_q;
  assign returnNickel      = rn_q;
  assign coinReject        = rej_q;
  assign busy              = busy_q;
endmodule
